// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with programmable data width, parity and stop bits.
// Delivers each word as a one-cycle valid pulse with parity and framing flags.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int N  = DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(N + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BREAK = 3'd5;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  logic [2:0]             state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_acc;
  logic                   ferr;
  logic                   tick;
  logic                   last_data;
  logic                   last_stop;
  logic                   done;

  assign rxs       = sync[SYNC_STAGES-1];
  assign tick      = (cnt == '0);
  assign last_data = (bit_idx == IW'(DATA_BITS - 1));
  assign last_stop = (bit_idx == IW'(STOP_BITS - 1));
  assign done      = (state == S_STOP) && tick && last_stop;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!rxs) state_nxt = S_START;
      S_START: if (tick) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA:  if (tick && last_data) state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (tick) state_nxt = S_STOP;
      // a low stop sample parks the FSM until the line returns high
      S_STOP:  if (done) state_nxt = (ferr || !rxs) ? S_BREAK : S_IDLE;
      S_BREAK: if (rxs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync       <= '1;
      state      <= S_IDLE;
      busy       <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      ferr       <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], rx};
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);

      // IDLE preloads the half-bit delay so the start sample lands mid-bit
      if (state == S_IDLE)
        cnt <= CW'(H - 1);
      else if (tick)
        cnt <= CW'(CLKS_PER_BIT - 1);
      else
        cnt <= cnt - 1'b1;

      if (state_nxt != state)
        bit_idx <= '0;
      else if (tick && (state == S_DATA || state == S_STOP))
        bit_idx <= bit_idx + 1'b1;

      if (state == S_DATA && tick)
        shreg <= {rxs, shreg[DATA_BITS-1:1]};

      if (state == S_IDLE)
        par_acc <= 1'b0;
      else if (tick && (state == S_DATA || state == S_PAR))
        par_acc <= par_acc ^ rxs;

      if (state == S_IDLE)
        ferr <= 1'b0;
      else if (state == S_STOP && tick && !rxs)
        ferr <= 1'b1;

      valid <= done;
      if (done) begin
        data       <= shreg;
        parity_err <= (PARITY == 1) ? ~par_acc : (PARITY == 2) ? par_acc : 1'b0;
        frame_err  <= ferr | ~rxs;
      end else begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four configurations, table vectors, corner sequences
// and random frames checked through per-instance expectation queues.
module tb_uart_rx_param;

  localparam int CPB [4] = '{16, 16, 4, 5};
  localparam int NB  [4] = '{8, 8, 9, 5};
  localparam int PAR [4] = '{0, 2, 1, 2};
  localparam int STP [4] = '{1, 1, 2, 1};
  localparam int SYN [4] = '{2, 2, 3, 2};

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } exp_t;

  typedef struct {
    int         dut;
    logic [8:0] d;
    logic       pbit;
    logic [1:0] stop_v;
    logic [8:0] x_data;
    logic       x_perr;
    logic       x_ferr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_l    [4];
  logic [8:0] data_w  [4];
  logic       valid_w [4];
  logic       perr_w  [4];
  logic       ferr_w  [4];
  logic       busy_w  [4];
  logic [7:0] d0_data, d1_data;
  logic [8:0] d2_data;
  logic [4:0] d3_data;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  exp_t q0[$], q1[$], q2[$], q3[$];
  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLKS_PER_BIT(CPB[0]), .DATA_BITS(NB[0]), .PARITY(PAR[0]), .STOP_BITS(STP[0]), .SYNC_STAGES(SYN[0])) d0 (
    .clk(clk), .rst(rst), .rx(rx_l[0]), .data(d0_data), .valid(valid_w[0]),
    .parity_err(perr_w[0]), .frame_err(ferr_w[0]), .busy(busy_w[0]));
  uart_rx_param #(.CLKS_PER_BIT(CPB[1]), .DATA_BITS(NB[1]), .PARITY(PAR[1]), .STOP_BITS(STP[1]), .SYNC_STAGES(SYN[1])) d1 (
    .clk(clk), .rst(rst), .rx(rx_l[1]), .data(d1_data), .valid(valid_w[1]),
    .parity_err(perr_w[1]), .frame_err(ferr_w[1]), .busy(busy_w[1]));
  uart_rx_param #(.CLKS_PER_BIT(CPB[2]), .DATA_BITS(NB[2]), .PARITY(PAR[2]), .STOP_BITS(STP[2]), .SYNC_STAGES(SYN[2])) d2 (
    .clk(clk), .rst(rst), .rx(rx_l[2]), .data(d2_data), .valid(valid_w[2]),
    .parity_err(perr_w[2]), .frame_err(ferr_w[2]), .busy(busy_w[2]));
  uart_rx_param #(.CLKS_PER_BIT(CPB[3]), .DATA_BITS(NB[3]), .PARITY(PAR[3]), .STOP_BITS(STP[3]), .SYNC_STAGES(SYN[3])) d3 (
    .clk(clk), .rst(rst), .rx(rx_l[3]), .data(d3_data), .valid(valid_w[3]),
    .parity_err(perr_w[3]), .frame_err(ferr_w[3]), .busy(busy_w[3]));

  assign data_w[0] = {1'b0, d0_data};
  assign data_w[1] = {1'b0, d1_data};
  assign data_w[2] = d2_data;
  assign data_w[3] = {4'b0, d3_data};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int q_total();
    return q0.size() + q1.size() + q2.size() + q3.size();
  endfunction

  task automatic push_exp(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  // Reference: expected word, parity flag and framing flag for one frame
  function automatic exp_t model(input int i, input logic [8:0] d, input logic pbit, input logic [1:0] sv);
    exp_t e;
    logic [8:0] mask;
    logic x;
    mask   = 9'h1FF >> (9 - NB[i]);
    x      = (^(d & mask)) ^ pbit;
    e.data = d & mask;
    e.perr = (PAR[i] == 0) ? 1'b0 : (PAR[i] == 2) ? x : ~x;
    e.ferr = !sv[0] || (STP[i] == 2 && !sv[1]);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic bit_out(input int i, input logic v);
    rx_l[i] = v;
    repeat (CPB[i]) @(negedge clk);
  endtask

  // Call at a negedge; returns at the negedge ending the last stop bit, line left as driven
  task automatic send(input int i, input logic [8:0] d, input logic pbit, input logic [1:0] sv,
                      input bit do_push, input exp_t e);
    int n;
    n = NB[i] + ((PAR[i] != 0) ? 1 : 0) + STP[i];
    e.cyc = cyc + SYN[i] + CPB[i] / 2 + n * CPB[i] + 1;
    if (do_push) push_exp(i, e);
    bit_out(i, 1'b0);
    for (int k = 0; k < NB[i]; k++) bit_out(i, d[k]);
    if (PAR[i] != 0) bit_out(i, pbit);
    for (int s = 0; s < STP[i]; s++) bit_out(i, sv[s]);
  endtask

  task automatic idle(input int i, input int bits);
    rx_l[i] = 1'b1;
    repeat (bits * CPB[i]) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (valid_w[i]) begin
          exp_t e;
          bit have;
          have = 1'b0;
          case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
          endcase
          if (!have) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid: dut %0d got valid data 0x%0h, expected none", i, data_w[i]);
          end else begin
            chk($sformatf("data[%0d]", i), 32'(data_w[i]), 32'(e.data));
            chk($sformatf("parity_err[%0d]", i), 32'(perr_w[i]), 32'(e.perr));
            chk($sformatf("frame_err[%0d]", i), 32'(ferr_w[i]), 32'(e.ferr));
            chk($sformatf("valid_cycle[%0d]", i), 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   k;
    int   t;
    vec_t v;
    logic [8:0] rd;
    logic       rp;
    logic [1:0] rs;

    for (int i = 0; i < 4; i++) rx_l[i] = 1'b1;

    vecs.push_back('{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0});
    vecs.push_back('{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0});
    vecs.push_back('{0, 9'h001, 1'b0, 2'b10, 9'h001, 1'b0, 1'b1});
    vecs.push_back('{1, 9'h003, 1'b1, 2'b11, 9'h003, 1'b1, 1'b0});
    vecs.push_back('{1, 9'h003, 1'b0, 2'b11, 9'h003, 1'b0, 1'b0});
    vecs.push_back('{1, 9'h007, 1'b1, 2'b11, 9'h007, 1'b0, 1'b0});
    vecs.push_back('{1, 9'h007, 1'b0, 2'b11, 9'h007, 1'b1, 1'b0});
    vecs.push_back('{2, 9'h1FF, 1'b0, 2'b01, 9'h1FF, 1'b0, 1'b1});
    vecs.push_back('{2, 9'h100, 1'b0, 2'b11, 9'h100, 1'b0, 1'b0});
    vecs.push_back('{2, 9'h000, 1'b0, 2'b11, 9'h000, 1'b1, 1'b0});
    vecs.push_back('{2, 9'h0AA, 1'b1, 2'b10, 9'h0AA, 1'b0, 1'b1});
    vecs.push_back('{3, 9'h015, 1'b1, 2'b11, 9'h015, 1'b0, 1'b0});
    vecs.push_back('{3, 9'h01F, 1'b0, 2'b11, 9'h01F, 1'b1, 1'b0});
    vecs.push_back('{3, 9'h00A, 1'b0, 2'b10, 9'h00A, 1'b0, 1'b1});

    #3;
    chk("rst_data", 32'(d0_data), 0);
    chk("rst_valid", 32'(valid_w[0]), 0);
    chk("rst_perr", 32'(perr_w[1]), 0);
    chk("rst_ferr", 32'(ferr_w[2]), 0);
    chk("rst_busy", 32'(busy_w[3]), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    foreach (vecs[n]) begin
      v = vecs[n];
      e.data = v.x_data;
      e.perr = v.x_perr;
      e.ferr = v.x_ferr;
      send(v.dut, v.d, v.pbit, v.stop_v, 1'b1, e);
      idle(v.dut, 3);
    end

    // short glitch on an idle line
    k = cyc;
    rx_l[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_l[0] = 1'b1;
    chk("glitch_busy_on", 32'(busy_w[0]), 1);
    while (cyc < k + 10) @(negedge clk);
    chk("glitch_busy_c8", 32'(busy_w[0]), 1);
    @(negedge clk);
    chk("glitch_idle_c9", 32'(busy_w[0]), 0);
    idle(0, 2);

    // stop bit low followed by a held-low break
    e = model(0, 9'h000, 1'b0, 2'b00);
    send(0, 9'h000, 1'b0, 2'b00, 1'b1, e);
    repeat (3 * CPB[0]) @(negedge clk);
    chk("break_busy", 32'(busy_w[0]), 1);
    idle(0, 2);
    chk("break_released", 32'(busy_w[0]), 0);
    send(0, 9'h05A, 1'b0, 2'b11, 1'b1, model(0, 9'h05A, 1'b0, 2'b11));
    idle(0, 2);

    // back-to-back frames with no idle gap
    send(0, 9'h012, 1'b0, 2'b11, 1'b1, model(0, 9'h012, 1'b0, 2'b11));
    send(0, 9'h034, 1'b0, 2'b11, 1'b1, model(0, 9'h034, 1'b0, 2'b11));
    idle(0, 2);

    // reset during data bit 3
    bit_out(0, 1'b0);
    for (int b = 0; b < 3; b++) bit_out(0, b < 2);
    rx_l[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data", 32'(d0_data), 0);
    chk("async_rst_busy", 32'(busy_w[0]), 0);
    chk("async_rst_valid", 32'(valid_w[0]), 0);
    rx_l[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(0, 2);
    send(0, 9'h0C3, 1'b0, 2'b11, 1'b1, model(0, 9'h0C3, 1'b0, 2'b11));
    idle(0, 2);

    // random frames on every configuration
    for (int i = 0; i < 4; i++) begin
      for (int f = 0; f < 12; f++) begin
        rd = 9'($urandom);
        rp = 1'($urandom);
        rs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        send(i, rd, rp, rs, 1'b1, model(i, rd, rp, rs));
        idle(i, 1 + $urandom_range(0, 1));
      end
    end

    t = 0;
    while (q_total() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("pending_expectations", 32'(q_total()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
